// File: rtl/user_button_pulser.sv
// -----------------------------------------------------------------------------
// user_button_pulser
//
// Turns the two raw user push-buttons into clean single-cycle up/down blips
// for the user counter. Each channel synchronizes its raw pin through two
// flops, debounces it, and runs a small press FSM. The FSM emits a blip on the
// press, a repeat blip after REPEAT_DELAY, and then one every REPEAT_PERIOD
// while the button is held. Requests from the two channels that land in the
// same cycle cancel each other.
//
// Ports:
//   Clk100M   - system clock, rising edge
//   reset     - asynchronous active-low reset
//   btnUp     - raw up button, active-high, asynchronous
//   btnDown   - raw down button, active-high, asynchronous
//   enable    - gates blip generation only; the channels keep running
//   upBlip    - registered one-cycle up pulse
//   downBlip  - registered one-cycle down pulse
//   upLevel   - debounced level of btnUp
//   downLevel - debounced level of btnDown
// -----------------------------------------------------------------------------
module user_button_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic Clk100M,
  input  logic reset,
  input  logic btnUp,
  input  logic btnDown,
  input  logic enable,
  output logic upBlip,
  output logic downBlip,
  output logic upLevel,
  output logic downLevel
);

  localparam int CW = 27;

  // Terminal values: a counter reaching N means it held N-1 before the edge.
  localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST    = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST   = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEAT     = 2'd2
  } pressState_t;

  // Channel 0 is up, channel 1 is down.
  logic [1:0] rawPins;
  logic [1:0] stableLevel;
  logic [1:0] blipReq;

  assign rawPins = {btnDown, btnUp};

  for (genvar gi = 0; gi < 2; gi++) begin : gChannel
    logic          sync1Reg;
    logic          sync2Reg;
    logic          stableReg;
    logic [CW-1:0] debounceCntReg;
    logic [CW-1:0] repeatCntReg;
    logic [CW-1:0] repeatCntNext;
    pressState_t   stateReg;
    pressState_t   stateNext;
    logic          req;

    // Synchronizer and debouncer. The counter tracks how long sync2 has
    // disagreed with the accepted level; any agreement restarts the count.
    always_ff @(posedge Clk100M or negedge reset) begin
      if (!reset) begin
        sync1Reg       <= 1'b0;
        sync2Reg       <= 1'b0;
        stableReg      <= 1'b0;
        debounceCntReg <= '0;
      end else begin
        sync1Reg <= rawPins[gi];
        sync2Reg <= sync1Reg;
        if (sync2Reg != stableReg) begin
          if (debounceCntReg == DEBOUNCE_LAST) begin
            stableReg      <= sync2Reg;
            debounceCntReg <= '0;
          end else begin
            debounceCntReg <= debounceCntReg + 1'b1;
          end
        end else begin
          debounceCntReg <= '0;
        end
      end
    end

    always_ff @(posedge Clk100M or negedge reset) begin
      if (!reset) begin
        stateReg     <= IDLE;
        repeatCntReg <= '0;
      end else begin
        stateReg     <= stateNext;
        repeatCntReg <= repeatCntNext;
      end
    end

    // Release is checked first so it overrides a repeat due in the same cycle.
    // IDLE with stable high can only follow a 0->1 transition, because any
    // low level forces IDLE.
    always_comb begin
      stateNext     = stateReg;
      repeatCntNext = repeatCntReg;
      req           = 1'b0;
      if (!stableReg) begin
        stateNext     = IDLE;
        repeatCntNext = '0;
      end else begin
        case (stateReg)
          IDLE: begin
            stateNext     = HOLD_DELAY;
            repeatCntNext = '0;
            req           = 1'b1;
          end
          HOLD_DELAY: begin
            if (repeatCntReg == DELAY_LAST) begin
              stateNext     = REPEAT;
              repeatCntNext = '0;
              req           = 1'b1;
            end else begin
              repeatCntNext = repeatCntReg + 1'b1;
            end
          end
          REPEAT: begin
            if (repeatCntReg == PERIOD_LAST) begin
              repeatCntNext = '0;
              req           = 1'b1;
            end else begin
              repeatCntNext = repeatCntReg + 1'b1;
            end
          end
          default: begin
            stateNext     = IDLE;
            repeatCntNext = '0;
          end
        endcase
      end
    end

    assign stableLevel[gi] = stableReg;
    assign blipReq[gi]     = req;
  end

  // Coincident requests are dropped outright so the counter never sees both.
  always_ff @(posedge Clk100M or negedge reset) begin
    if (!reset) begin
      upBlip   <= 1'b0;
      downBlip <= 1'b0;
    end else begin
      upBlip   <= blipReq[0] & ~blipReq[1] & enable;
      downBlip <= blipReq[1] & ~blipReq[0] & enable;
    end
  end

  assign upLevel   = stableLevel[0];
  assign downLevel = stableLevel[1];

endmodule

// File: tb/tb_user_button_pulser.sv
// -----------------------------------------------------------------------------
// tb_user_button_pulser
//
// Directed bench for user_button_pulser with short debounce/repeat constants.
// Blip rise times are logged as posedge indices and compared with
// hand-computed schedules.
// -----------------------------------------------------------------------------
module tb_user_button_pulser;

  logic Clk100M = 1'b0;
  logic reset;
  logic btnUp;
  logic btnDown;
  logic enable;
  logic upBlip;
  logic downBlip;
  logic upLevel;
  logic downLevel;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int overlap  = 0;
  int upTimes[$];
  int downTimes[$];

  user_button_pulser #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .Clk100M  (Clk100M),
    .reset    (reset),
    .btnUp    (btnUp),
    .btnDown  (btnDown),
    .enable   (enable),
    .upBlip   (upBlip),
    .downBlip (downBlip),
    .upLevel  (upLevel),
    .downLevel(downLevel)
  );

  always #5 Clk100M = ~Clk100M;

  // cyc is the index of the most recent rising edge.
  always @(posedge Clk100M) cyc <= cyc + 1;

  always @(negedge Clk100M) begin
    if (upBlip === 1'b1)   upTimes.push_back(cyc);
    if (downBlip === 1'b1) downTimes.push_back(cyc);
    if (upBlip === 1'b1 && downBlip === 1'b1) overlap++;
  end

  task automatic checkValue(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Returns 1 time unit after the n-th following rising edge.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge Clk100M);
    #1;
  endtask

  initial begin
    int c;
    int r;
    int expUp[6];

    reset   = 1'b0;
    btnUp   = 1'b0;
    btnDown = 1'b0;
    enable  = 1'b1;
    waitCycles(3);
    checkValue("rst_upBlip",    32'(upBlip),    0);
    checkValue("rst_downBlip",  32'(downBlip),  0);
    checkValue("rst_upLevel",   32'(upLevel),   0);
    checkValue("rst_downLevel", 32'(downLevel), 0);
    reset = 1'b1;
    waitCycles(5);
    $display("txn reset done at cycle %0d", cyc);

    // Single press: blip after edge 6, level rises at edge 5.
    upTimes.delete(); downTimes.delete();
    c = cyc;
    btnUp = 1'b1;
    waitCycles(5);
    checkValue("single_level_edge4", 32'(upLevel), 0);
    waitCycles(1);
    checkValue("single_level_edge5", 32'(upLevel), 1);
    waitCycles(4);
    btnUp = 1'b0;
    waitCycles(30);
    checkValue("single_up_count",   32'(upTimes.size()), 1);
    checkValue("single_up_time",    32'(upTimes[0] - c), 7);
    checkValue("single_down_count", 32'(downTimes.size()), 0);
    checkValue("single_level_fall", 32'(upLevel), 0);
    $display("txn single press base=%0d blips=%0d", c, upTimes.size());

    // Bounce: 2-cycle runs never satisfy a 4-cycle debounce.
    upTimes.delete(); downTimes.delete();
    for (int i = 0; i < 15; i++) begin
      btnDown = 1'(i % 2);
      waitCycles(2);
    end
    checkValue("bounce_level", 32'(downLevel), 0);
    checkValue("bounce_no_blip", 32'(downTimes.size()), 0);
    c = cyc;
    btnDown = 1'b1;
    waitCycles(10);
    btnDown = 1'b0;
    waitCycles(30);
    checkValue("bounce_down_count", 32'(downTimes.size()), 1);
    checkValue("bounce_down_time",  32'(downTimes[0] - c), 7);
    checkValue("bounce_up_count",   32'(upTimes.size()), 0);
    $display("txn bounce hold base=%0d blips=%0d", c, downTimes.size());

    // Auto-repeat: the t+60 repeat lands right after the level falls and
    // must be suppressed.
    upTimes.delete(); downTimes.delete();
    expUp = '{7, 27, 35, 43, 51, 59};
    c = cyc;
    btnUp = 1'b1;
    waitCycles(60);
    btnUp = 1'b0;
    waitCycles(30);
    checkValue("repeat_count", 32'(upTimes.size()), 6);
    for (int i = 0; i < 6; i++)
      checkValue($sformatf("repeat_time%0d", i), 32'(upTimes[i] - c), 32'(expUp[i]));
    $display("txn auto-repeat base=%0d blips=%0d", c, upTimes.size());

    // Coincidence: both levels rise, every request cancels.
    upTimes.delete(); downTimes.delete();
    c = cyc;
    btnUp   = 1'b1;
    btnDown = 1'b1;
    waitCycles(6);
    checkValue("coin_upLevel",   32'(upLevel), 1);
    checkValue("coin_downLevel", 32'(downLevel), 1);
    waitCycles(24);
    btnUp   = 1'b0;
    btnDown = 1'b0;
    waitCycles(30);
    checkValue("coin_up_count",   32'(upTimes.size()), 0);
    checkValue("coin_down_count", 32'(downTimes.size()), 0);
    $display("txn coincidence base=%0d", c);

    // Enable masking: first blip masked, repeat at t+20 appears.
    upTimes.delete(); downTimes.delete();
    c = cyc;
    enable = 1'b0;
    btnUp  = 1'b1;
    waitCycles(15);
    checkValue("enable_masked", 32'(upTimes.size()), 0);
    enable = 1'b1;
    waitCycles(13);
    btnUp = 1'b0;
    waitCycles(30);
    checkValue("enable_count", 32'(upTimes.size()), 1);
    checkValue("enable_time",  32'(upTimes[0] - c), 27);
    $display("txn enable mask base=%0d blips=%0d", c, upTimes.size());

    // Async reset during REPEAT, then a fresh press after release.
    upTimes.delete(); downTimes.delete();
    c = cyc;
    btnUp = 1'b1;
    waitCycles(30);
    checkValue("areset_level_before", 32'(upLevel), 1);
    #3 reset = 1'b0;
    #1;
    checkValue("areset_upLevel",  32'(upLevel), 0);
    checkValue("areset_upBlip",   32'(upBlip), 0);
    checkValue("areset_downBlip", 32'(downBlip), 0);
    waitCycles(3);
    reset = 1'b1;
    upTimes.delete();
    r = cyc;
    waitCycles(28);
    btnUp = 1'b0;
    waitCycles(30);
    checkValue("areset_count", 32'(upTimes.size()), 2);
    checkValue("areset_first", 32'(upTimes[0] - r), 7);
    checkValue("areset_second", 32'(upTimes[1] - r), 27);
    $display("txn async reset release=%0d blips=%0d", r, upTimes.size());

    checkValue("never_both_high", 32'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_button_pulser.md
# user_button_pulser

Conditions the two raw user push-buttons into the clean single-cycle `up`/`down` blips consumed by the user counter in the game-play datapath. It runs in the Clk100M domain. Per channel it synchronizes the raw pin, debounces it, and detects the press edge. Held buttons auto-repeat, and coincident up/down events cancel so the counter never sees both in one cycle.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronized level must differ from the stable level before it is accepted (10 ms). Range 2..2^27-1.
- REPEAT_DELAY, 50000000: cycles from the first blip of a held press to the first repeat blip (500 ms). Range 2..2^27-1.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat blips (100 ms). Range 2..2^27-1.
- Clk100M  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to Clk100M.
- btnUp  input  1  raw, asynchronous up button, active-high.
- btnDown  input  1  raw, asynchronous down button, active-high.
- enable  input  1  blips are produced only while high (tied to the counting window).
- upBlip  output  1  one-cycle up pulse, registered.
- downBlip  output  1  one-cycle down pulse, registered.
- upLevel  output  1  debounced stable level of btnUp.
- downLevel  output  1  debounced stable level of btnDown.

## Operation
- Per channel, in order: 2-FF synchronizer (sync1 -> sync2), then debouncer, then press FSM. Both channels are identical, and all counters are 27 bits.
- Debouncer:
  - The counter increments on each edge where sync2 != stable and clears on each edge where they are equal.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, stable takes the value of sync2 and the counter clears.
  - upLevel/downLevel are driven directly from stable.
- Press FSM states and transitions:
  - IDLE -> HOLD_DELAY on the stable 0->1 edge. This requests a blip and clears the repeat counter.
  - HOLD_DELAY counts cycles. When REPEAT_DELAY cycles have elapsed since the first blip, it requests a blip, clears the counter, and goes to REPEAT.
  - REPEAT requests a blip every REPEAT_PERIOD cycles, clearing the counter each time.
  - Any state -> IDLE on stable == 0, with no blip and the counter cleared. Release takes priority over a same-cycle repeat request.
- Output stage:
  - upBlip <= reqUp & ~reqDown & enable.
  - downBlip <= reqDown & ~reqUp & enable.
  - Coincident requests are both dropped and not deferred.
- enable low masks blips only. The synchronizer, debouncer and FSM keep running, so a press held across enable rising produces its next repeat blip on schedule, not a fresh first blip.
- Glitches shorter than DEBOUNCE_CYCLES never change stable and never produce a blip.

## Timing
- Reset values: upBlip = downBlip = 0, upLevel = downLevel = 0, sync FFs = 0, stable = 0, FSM = IDLE, all counters = 0.
- Press latency, with edge 0 being the first edge sampling raw high:
  - sync2 is high after edge 1.
  - The debounce counter counts edges 2..DEBOUNCE_CYCLES+1.
  - stable rises at edge DEBOUNCE_CYCLES+1.
  - The blip is high for exactly the one cycle following edge DEBOUNCE_CYCLES+2.
- Release latency: the level falls at edge DEBOUNCE_CYCLES+1 after the first low sample, with no blip.
- Repeat timing:
  - The first repeat blip rises exactly REPEAT_DELAY cycles after the first blip rises.
  - Each subsequent repeat blip rises REPEAT_PERIOD cycles after the previous one.
- Blip width is always exactly 1 cycle. upBlip and downBlip are never high in the same cycle.
- Counters never wrap, because each is cleared at its terminal count.
- reset asserted mid-press: outputs are 0 immediately. After release, a still-held button needs the full press latency before its first blip. It is treated as a fresh press, not a repeat.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, enable=1 unless stated.
- Single press: btnUp high for 10 cycles, then low -> upBlip one cycle after edge 6; upLevel high edges 5..; no further blips; downBlip stays 0.
- Bounce rejection: btnDown toggles every 2 cycles for 30 cycles, then is held high -> no blip during bounce; exactly one downBlip 7 edges after the hold begins.
- Auto-repeat: btnUp held for 60 cycles -> blips at t, t+20, t+28, t+36, t+44, t+52 relative to the first blip; none after release.
- Coincidence: btnUp and btnDown rise on the same edge -> upLevel and downLevel both high at edge 5; no blip on either output at edge 6 or at the repeat instants.
- Enable masking: hold btnUp with enable=0 through the first blip, then raise enable -> first upBlip appears at the scheduled repeat time t+20, not earlier.
- Async reset: drive reset low during REPEAT -> all outputs 0 within the same cycle. After release with btnUp still high, the first upBlip comes 7 edges later, then the next at +20.
